s2p_converter: RTL and testbench



---
 rtl/serdes_pkg.sv | 14 +
 rtl/word_out_reg.sv | 43 ++++
 rtl/s2p_converter.sv | 110 +++++++++++
 tb/tb_s2p_converter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: definitions shared by the serial/parallel converters.
//   conv_state_e     : two-state converter FSM encoding (SHIFT, FULL), common
//                      to the upstream parallel-to-serial side and this one.
//   SERDES_LSB_FIRST : bit order on the serial link (1 = LSB of word first).
package serdes_pkg;

  typedef enum logic [0:0] {
    SHIFT = 1'b0,
    FULL  = 1'b1
  } conv_state_e;

  localparam logic SERDES_LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_out_reg.sv
// word_out_reg: single-entry valid/ready holding register for a parallel word.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   in_data/in_valid     : word offered by the producer
//   in_ready             : register can take a word this cycle
//   out_data/out_valid   : held word, stable while out_valid is high
//   out_ready            : consumer accepts out_data this cycle
// A word may be loaded on the same edge the held word is delivered, so a
// continuously ready consumer sees no bubble.
module word_out_reg
  import serdes_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // Free when empty or when the held word leaves on this edge.
  assign in_ready = !out_valid || out_ready;

  // Load a new word, or drop valid once the held word has been taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= {N{1'b0}};
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/s2p_converter.sv
// s2p_converter: reassembles an LSB-first serial bit stream into N-bit words.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   s_data/s_valid   : serial bit and its valid
//   s_ready          : a serial bit can be accepted (depends on state only)
//   p_data/p_valid   : assembled word from the output holding register
//   p_ready          : consumer accepts p_data this cycle
// Bits shift in from the top so the first accepted bit ends in bit 0. After
// the last bit the FSM sits in FULL (serial side stalled) until the output
// register can take the word; a stalled consumer therefore back-pressures
// the serial link instead of losing data.
module s2p_converter
  import serdes_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready
);

  localparam int             CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  conv_state_e   state_r;
  conv_state_e   state_s;
  logic [N-1:0]  sr_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;
  logic          last_bit_s;
  logic          out_free_s;
  logic          word_valid_s;

  assign s_ready      = (state_r == SHIFT);
  assign accept_s     = s_valid && s_ready;
  assign last_bit_s   = (cnt_r == CNT_LAST);
  assign word_valid_s = (state_r == FULL);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= SHIFT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: complete a word in SHIFT, hand it off in FULL.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SHIFT: begin
        if (accept_s && last_bit_s) begin
          state_s = FULL;
        end else begin
          state_s = SHIFT;
        end
      end
      FULL: begin
        if (out_free_s) begin
          state_s = SHIFT;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = SHIFT;
      end
    endcase
  end

  // Shift register and bit counter; both hold unless a bit is accepted.
  // The counter wraps only through the last-bit path, so it never exceeds
  // N-1 even when N is not a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_r  <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      sr_r <= {s_data, sr_r[N-1:1]};
      if (last_bit_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      sr_r  <= sr_r;
      cnt_r <= cnt_r;
    end
  end

  word_out_reg #(
    .N(N)
  ) u_word_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (sr_r),
    .in_valid (word_valid_s),
    .in_ready (out_free_s),
    .out_data (p_data),
    .out_valid(p_valid),
    .out_ready(p_ready)
  );

endmodule

// File: tb/tb_s2p_converter.sv
// tb_s2p_converter: self-checking bench for s2p_converter (N=4).
// A transaction-level model (bit count, word-in-waiting flag, output slot)
// predicts s_ready/p_valid/p_data every cycle; directed scenarios add
// constant expectations and a random loopback run checks word order.
module tb_s2p_converter;

  localparam int N = 4;

  logic         clk;
  logic         rstn;
  logic         s_data;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         p_ready;

  int checks;
  int failures;

  // model state
  int           m_bits;
  logic [N-1:0] m_acc;
  logic         m_full;
  logic [N-1:0] m_word;
  logic         m_pv;
  logic [N-1:0] m_pd;

  logic         d_acc;
  logic         d_dlv;
  logic [N-1:0] d_word;

  s2p_converter #(.N(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .p_data (p_data),
    .p_valid(p_valid),
    .p_ready(p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits = 0;
    m_acc  = '0;
    m_full = 1'b0;
    m_word = '0;
    m_pv   = 1'b0;
    m_pd   = '0;
  endtask

  // Called at a negedge: asynchronous reset, immediate output check, release.
  task automatic do_reset();
    #2 rstn = 1'b0;
    s_valid = 1'b0;
    p_ready = 1'b0;
    #1;
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check_eq("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check_eq("rst_p_data", {28'd0, p_data}, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock cycle starting and ending at a negedge.
  task automatic cycle(input logic sv, input logic sd, input logic pr,
                       output logic acc, output logic dlv, output logic [N-1:0] dword);
    logic xfer;
    check_eq("s_ready", {31'd0, s_ready}, {31'd0, !m_full});
    check_eq("p_valid", {31'd0, p_valid}, {31'd0, m_pv});
    check_eq("p_data", {28'd0, p_data}, {28'd0, m_pd});
    s_valid = sv;
    s_data  = sd;
    p_ready = pr;
    acc   = sv && !m_full;
    dlv   = m_pv && pr;
    dword = p_data;
    xfer  = m_full && (!m_pv || pr);
    if (xfer) begin
      m_pd   = m_word;
      m_pv   = 1'b1;
      m_full = 1'b0;
    end else if (dlv) begin
      m_pv = 1'b0;
    end
    if (acc) begin
      m_acc[m_bits] = sd;
      m_bits++;
      if (m_bits == N) begin
        m_word = m_acc;
        m_full = 1'b1;
        m_bits = 0;
        m_acc  = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input logic sv, input logic sd, input logic pr);
    cycle(sv, sd, pr, d_acc, d_dlv, d_word);
  endtask

  // Sends a word LSB first on consecutive cycles with a fixed p_ready.
  task automatic send_word(input logic [N-1:0] w, input logic pr);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, w[i], pr);
    end
  endtask

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] exp_w;
    bit           tx_q[$];
    logic [N-1:0] exp_q[$];
    int           n_dlv;
    int           budget;

    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_data   = 1'b0;
    p_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single word 1,0,1,1 -> 4'b1101
    send_word(4'b1101, 1'b1);
    check_eq("sw_stall", {31'd0, s_ready}, 32'd0);
    check_eq("sw_pv_early", {31'd0, p_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("sw_pv", {31'd0, p_valid}, 32'd1);
    check_eq("sw_pd", {28'd0, p_data}, 32'hD);
    check_eq("sw_sready_back", {31'd0, s_ready}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("sw_pv_one", {31'd0, p_valid}, 32'd0);
    check_eq("sw_pd_hold", {28'd0, p_data}, 32'hD);

    // Back-pressure: A then 5 with consumer stalled
    send_word(4'hA, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    send_word(4'h5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      check_eq("bp_pd_hold", {28'd0, p_data}, 32'hA);
      check_eq("bp_sready", {31'd0, s_ready}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("bp_pv_cont", {31'd0, p_valid}, 32'd1);
    check_eq("bp_pd_new", {28'd0, p_data}, 32'h5);
    check_eq("bp_sready_rel", {31'd0, s_ready}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("bp_pv_drop", {31'd0, p_valid}, 32'd0);

    // Gappy source: 4'h6 with idle cycles between bits
    w = 4'h6;
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, w[i], 1'b1);
      cyc(1'b0, ~w[i], 1'b1);
    end
    check_eq("gap_pv", {31'd0, p_valid}, 32'd1);
    check_eq("gap_pd", {28'd0, p_data}, 32'h6);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset mid-word, then 4'h9
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    do_reset();
    send_word(4'h9, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("rmw_pv", {31'd0, p_valid}, 32'd1);
    check_eq("rmw_pd", {28'd0, p_data}, 32'h9);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("rmw_single", {31'd0, p_valid}, 32'd0);

    // Loopback: 200 random words, random gaps and random p_ready
    for (int i = 0; i < 200; i++) begin
      w = N'($urandom_range(0, (1 << N) - 1));
      exp_q.push_back(w);
      for (int b = 0; b < N; b++) begin
        tx_q.push_back(w[b]);
      end
    end
    n_dlv  = 0;
    budget = 0;
    while (n_dlv < 200 && budget < 6000) begin
      logic sv;
      logic sd;
      logic pr;
      sv = (tx_q.size() > 0) && ($urandom_range(0, 3) != 0);
      sd = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
      pr = ($urandom_range(0, 2) != 0);
      cycle(sv, sd, pr, d_acc, d_dlv, d_word);
      if (d_acc) begin
        void'(tx_q.pop_front());
      end
      if (d_dlv) begin
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check_eq("lb_word", {28'd0, d_word}, {28'd0, exp_w});
        end else begin
          check_eq("lb_extra", {28'd0, d_word}, 32'hFFFF_FFFF);
        end
        n_dlv++;
      end
      budget++;
    end
    check_eq("lb_count", n_dlv, 32'd200);
    check_eq("lb_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
